// File: rtl/dmi_jtag_access.sv
// JTAG-side DMI initiator: owns the 41-bit DMI DR and issues one request at a time into the DMI CDC.
// Request valid one tck after Update-DR, held until ready; responses are always accepted outside Read/Write.
package dm;
    localparam int unsigned DataWidth    = 32;
    localparam int unsigned DmiAddrWidth = 7;

    typedef struct packed {
        logic [DmiAddrWidth-1:0] addr;
        logic [1:0]              op;
        logic [DataWidth-1:0]    data;
    } dmi_req_t;

    typedef struct packed {
        logic [DataWidth-1:0] data;
        logic [1:0]           resp;
    } dmi_resp_t;
endpackage

module dmi_jtag_access #(
    parameter int unsigned AddrWidth = 7
) (
    input  logic          tck_i,
    input  logic          trst_ni,
    input  logic          dmi_select_i,
    input  logic          capture_dr_i,
    input  logic          shift_dr_i,
    input  logic          update_dr_i,
    input  logic          test_logic_reset_i,
    input  logic          tdi_i,
    output logic          tdo_o,
    input  logic          dmireset_i,
    input  logic          dmihardreset_i,
    output logic [1:0]    dmistat_o,
    output dm::dmi_req_t  dmi_req_o,
    output logic          dmi_req_valid_o,
    input  logic          dmi_req_ready_i,
    input  dm::dmi_resp_t dmi_resp_i,
    input  logic          dmi_resp_valid_i,
    output logic          dmi_resp_ready_o,
    output logic          dmi_clear_o
);
    localparam int unsigned DataWidth = dm::DataWidth;
    localparam int unsigned DrWidth   = AddrWidth + DataWidth + 2;

    localparam logic [1:0] OpRead   = 2'd1;
    localparam logic [1:0] OpWrite  = 2'd2;
    localparam logic [1:0] StNone   = 2'd0;
    localparam logic [1:0] StFailed = 2'd2;
    localparam logic [1:0] StBusy   = 2'd3;

    typedef enum logic [2:0] {
        Idle,
        Read,
        WaitRead,
        Write,
        WaitWrite
    } state_e;

    state_e                r_state;
    logic [AddrWidth-1:0]  r_addr;
    logic [DataWidth-1:0]  r_data;
    logic [DrWidth-1:0]    r_dr;
    logic [1:0]            r_error;
    logic                  r_clear;

    logic                  w_capture;
    logic                  w_shift;
    logic                  w_update;
    logic                  w_hard;
    logic                  w_busy;
    logic                  w_err_clean;
    logic [1:0]            w_dr_op;
    logic [AddrWidth-1:0]  w_dr_addr;
    logic [DataWidth-1:0]  w_dr_data;
    logic [1:0]            w_req_op;
    logic [1:0]            w_resp_err;

    assign w_capture   = capture_dr_i & dmi_select_i;
    assign w_shift     = shift_dr_i & dmi_select_i;
    assign w_update    = update_dr_i & dmi_select_i;
    assign w_hard      = dmihardreset_i | test_logic_reset_i;
    assign w_busy      = (r_state != Idle);
    assign w_err_clean = (r_error == StNone);

    assign w_dr_op   = r_dr[1:0];
    assign w_dr_data = r_dr[DataWidth+1:2];
    assign w_dr_addr = r_dr[DrWidth-1 -: AddrWidth];

    assign w_req_op = (r_state == Read)  ? OpRead  :
                      (r_state == Write) ? OpWrite : 2'd0;

    // Only failure codes latch into dmistat; success and reserved codes leave it alone.
    assign w_resp_err = ((dmi_resp_i.resp == StFailed) || (dmi_resp_i.resp == StBusy))
                        ? dmi_resp_i.resp : StNone;

    assign tdo_o            = r_dr[0];
    assign dmistat_o        = r_error;
    assign dmi_clear_o      = r_clear;
    assign dmi_req_valid_o  = (r_state == Read) || (r_state == Write);
    assign dmi_resp_ready_o = !dmi_req_valid_o;
    assign dmi_req_o        = {r_addr, w_req_op, r_data};

    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            r_state <= Idle;
            r_addr  <= '0;
            r_data  <= '0;
            r_dr    <= '0;
            r_error <= StNone;
            r_clear <= 1'b0;
        end else if (w_hard) begin
            // Abandon any in-flight request; the CDC is flushed by the clear pulse.
            r_state <= Idle;
            r_addr  <= '0;
            r_data  <= '0;
            r_error <= StNone;
            r_clear <= 1'b1;
        end else begin
            r_clear <= 1'b0;

            if (w_capture) begin
                r_dr <= {r_addr, r_data, (w_busy ? StBusy : r_error)};
                if (w_busy && w_err_clean) begin
                    r_error <= StBusy;
                end
            end else if (w_shift) begin
                r_dr <= {tdi_i, r_dr[DrWidth-1:1]};
            end

            unique case (r_state)
                Idle: begin
                    if (w_update && w_err_clean) begin
                        if (w_dr_op == OpRead) begin
                            r_addr  <= w_dr_addr;
                            r_state <= Read;
                        end else if (w_dr_op == OpWrite) begin
                            r_addr  <= w_dr_addr;
                            r_data  <= w_dr_data;
                            r_state <= Write;
                        end
                    end
                end
                Read: begin
                    if (dmi_req_ready_i) begin
                        r_state <= WaitRead;
                    end
                end
                Write: begin
                    if (dmi_req_ready_i) begin
                        r_state <= WaitWrite;
                    end
                end
                WaitRead, WaitWrite: begin
                    if (dmi_resp_valid_i) begin
                        r_state <= Idle;
                        if ((r_state == WaitRead) && (dmi_resp_i.resp == StNone)) begin
                            r_data <= dmi_resp_i.data;
                        end
                        if (w_err_clean && (w_resp_err != StNone)) begin
                            r_error <= w_resp_err;
                        end
                    end
                end
                default: r_state <= Idle;
            endcase

            if (w_update && w_busy && w_err_clean) begin
                r_error <= StBusy;
            end

            if (dmireset_i) begin
                r_error <= StNone;
            end
        end
    end
endmodule
